// File: rtl/soc_pkg.sv
// Shared fetch-side definitions: FSM state encodings, default boot address and
// instruction width.
package soc_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with occupancy count, single-cycle flush and a
// show-ahead head output (head entry visible without a pop).
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 64
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  input  logic          i_Flush,
  input  logic          i_Push,
  input  logic [W-1:0]  i_Data,
  input  logic          i_Pop,
  output logic [W-1:0]  o_Head,
  output logic [AW:0]   o_Count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  // A flush cycle neither stores nor consumes anything.
  assign push_ok = i_Push && !i_Flush;
  assign pop_ok  = i_Pop  && !i_Flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the count alone defines which entries are live.
  always_ff @(posedge i_Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_Data;
  end

  assign o_Head  = mem_q[rd_ptr_q];
  assign o_Count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Avalon read master fetching instruction words into a prefetch FIFO for decode.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module instr_fetch
  import soc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 4,
  parameter int          FIFO_AW    = 2
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  output logic [31:0]        o_AV_Address,
  output logic               o_AV_Read,
  input  logic [31:0]        i_AV_ReadData,
  input  logic               i_AV_WaitRequest,
  output logic               o_Instr_Valid,
  output logic [INSTR_W-1:0] o_Instr,
  output logic [31:0]        o_Instr_PC,
  input  logic               i_Instr_Ready,
  input  logic               i_Redirect,
  input  logic [31:0]        i_Redirect_PC,
  input  logic               i_Halt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        o_FetchCount,
  output logic [31:0]        o_StallCount
`endif
);

  localparam logic [FIFO_AW+1:0] DEPTH_L = (FIFO_AW+2)'(FIFO_DEPTH);

  fetch_state_e        state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         resp_pc_q, resp_pc_d;
  logic                inflight_q, inflight_d;
  logic                drop_q, drop_d;

  logic [FIFO_AW:0]    fifo_count;
  logic [FIFO_AW+1:0]  occupancy;
  logic [2*INSTR_W-1:0] fifo_head;
  logic                redirect_eff, accept, push, pop;

  assign redirect_eff = i_Redirect && (state_q != S_BOOT);
  // Buffered plus in-flight words may never exceed the FIFO size.
  assign occupancy    = {1'b0, fifo_count} + {{(FIFO_AW+1){1'b0}}, inflight_q};
  assign o_AV_Read    = (state_q == S_FETCH) && !i_Redirect && (occupancy < DEPTH_L);
  assign o_AV_Address = pc_q;
  assign accept       = o_AV_Read && !i_AV_WaitRequest;
  assign push         = inflight_q && !drop_q && !redirect_eff;
  assign o_Instr_Valid = (fifo_count != '0);
  assign pop          = o_Instr_Valid && i_Instr_Ready && !redirect_eff;
  assign o_Instr      = o_Instr_Valid ? fifo_head[INSTR_W-1:0] : '0;
  assign o_Instr_PC   = o_Instr_Valid ? fifo_head[2*INSTR_W-1:INSTR_W] : '0;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = accept;
    drop_d     = drop_q;
    unique case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: if (i_Halt)  state_d = S_HALT;
      S_HALT:  if (!i_Halt) state_d = S_FETCH;
      default: state_d = S_BOOT;
    endcase
    if (redirect_eff) begin
      pc_d = {i_Redirect_PC[31:2], 2'b00};
    end else if (accept) begin
      pc_d = pc_q + 32'd4;
    end
    if (accept) resp_pc_d = pc_q;
    // Drop only matters if a read could still be outstanding past a redirect.
    if (redirect_eff)    drop_d = inflight_d;
    else if (inflight_q) drop_d = 1'b0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW),
    .W     (2*INSTR_W)
  ) u_fifo (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Flush (redirect_eff),
    .i_Push  (push),
    .i_Data  ({resp_pc_q, i_AV_ReadData}),
    .i_Pop   (pop),
    .o_Head  (fifo_head),
    .o_Count (fifo_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (push && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (o_AV_Read && i_AV_WaitRequest && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_FetchCount = fetch_cnt_q;
  assign o_StallCount = stall_cnt_q;
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Avalon read master that fetches 32-bit instruction words from the boot ROM / memory slave and buffers them in a small prefetch FIFO.
- Supplies the decode stage over a valid/ready interface and tracks the fetch PC.
- Handles control-flow redirects by flushing buffered and in-flight words.
- Sits directly upstream of the ROM's Avalon read port, through the system address decoder.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- FIFO_DEPTH, 4, prefetch buffer entries; power of two, minimum 2.
- FIFO_AW, 2, log2(FIFO_DEPTH).

Ports:
- i_Clk  in  1  system clock; all state on rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- o_AV_Address  out  32  byte address of the read; bits [1:0] always 0.
- o_AV_Read  out  1  read request.
- i_AV_ReadData  in  32  read data, valid exactly 1 cycle after an accepted read.
- i_AV_WaitRequest  in  1  slave stall; request held while high.
- o_Instr_Valid  out  1  buffered instruction available.
- o_Instr  out  32  instruction word at FIFO head.
- o_Instr_PC  out  32  byte address of o_Instr.
- i_Instr_Ready  in  1  decode consumes head when Valid && Ready.
- i_Redirect  in  1  one-cycle pulse: flush and restart fetch.
- i_Redirect_PC  in  32  new fetch address; bits [1:0] ignored and forced 0.
- i_Halt  in  1  level: stop issuing new reads.

Behaviour:
- Reset (async assert): state=S_BOOT, PC=RESET_PC, FIFO count=0, rd/wr ptr=0, inflight=0, drop=0. Outputs during reset: o_AV_Read=0, o_Instr_Valid=0, o_AV_Address=RESET_PC, o_Instr=0, o_Instr_PC=0.
- FSM states:
  - S_BOOT: one cycle after reset release, no reads; then S_FETCH.
  - S_FETCH: issues reads.
  - S_HALT: entered from S_FETCH when i_Halt=1; returns to S_FETCH when i_Halt=0.
  - Redirect is honoured in every state except S_BOOT, where it is ignored.
- Issue rule: o_AV_Read = (state==S_FETCH) && !i_Redirect && (count + inflight < FIFO_DEPTH); combinational. o_AV_Address = PC.
- Accept: o_AV_Read && !i_AV_WaitRequest. On accept: PC += 4 (wraps mod 2^32), inflight=1 for next cycle, and the issuing PC is latched as resp_pc.
- While WaitRequest=1, address and Read are held stable (PC unchanged).
- Response: in the cycle after accept, i_AV_ReadData and resp_pc are pushed to the FIFO unless drop=1, in which case the word is discarded. inflight clears unless a new accept occurs that cycle. Back-to-back accepts give 1 word/cycle throughput.
- Pop: Valid && Ready advances rd_ptr.
- Simultaneous push and pop: count unchanged. Pop while empty is impossible because Valid=0.
- Full: the issue rule prevents overflow; count never exceeds FIFO_DEPTH.
- Redirect cycle:
  - count, rd_ptr and wr_ptr cleared; PC=i_Redirect_PC & ~3; no read issued.
  - If a response arrives that cycle, it is discarded.
  - If a read was accepted the previous cycle, its data returns this cycle and is discarded.
  - drop is set only if inflight would persist (cannot occur given the issue rule), so drop stays 0 in normal operation.
  - o_Instr_Valid is 0 the following cycle.
  - Redirect wins over a simultaneous pop.
- i_Halt does not flush: buffered words still drain, and an in-flight response still lands.
- Pointer wrap: FIFO_AW-bit pointers wrap naturally; count is FIFO_AW+1 bits wide.
- Latency: redirect at cycle N -> read issued at N+1 -> data at N+2 -> o_Instr_Valid at N+3.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds ports o_FetchCount (32) and o_StallCount (32).
  - o_FetchCount: words pushed into the FIFO.
  - o_StallCount: cycles with o_AV_Read && i_AV_WaitRequest.
  - Both cleared on reset and saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent.

Decomposition:
- Shared package (soc_pkg): state encodings S_BOOT/S_FETCH/S_HALT, RESET_PC default, INSTR_W=32.
- One natural sub-module: fetch_fifo, a synchronous FIFO with count, flush input, and show-ahead head output.

Test Plan:
- Reset release with RESET_PC=0, ROM holding words 0x19008137, 0x7fc10113 at addresses 0/4; Ready=1 -> first read at cycle 2; o_Instr=0x19008137 with PC 0, then 0x7fc10113 with PC 4.
- Ready=0 for 10 cycles -> exactly FIFO_DEPTH=4 reads issued (addresses 0,4,8,12); o_AV_Read low afterwards. Ready=1 -> drains in order and issue resumes at address 16.
- WaitRequest high for 3 cycles on address 8 -> Address stays 8 and Read stays 1; o_StallCount=3 when the macro is defined; no duplicate or missing words.
- Redirect to 0x0000_00A6 while the FIFO holds 3 entries and one read is in flight -> Valid=0 next cycle; next o_Instr_PC=0xA4; no stale word delivered.
- Halt asserted mid-stream -> no new reads; buffered words still delivered; release -> fetch continues from the next sequential PC.
- Async reset asserted mid-burst -> all outputs immediately at reset values; fetch restarts at RESET_PC.
